// File: rtl/clb128_pkg.sv
// Shared constants, FSM encoding and round-index mapping for the CLB-128 round sequencer.
// Latency: not applicable; this file holds declarations only.
// Backpressure: not applicable; this file holds declarations only.
package clb128_pkg;

    localparam int NR = 20;   // rounds per block, legal 2..31
    localparam int W  = 128;  // cipher state width
    localparam int CW = 5;    // round counter width, 2**CW > NR

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Decryption walks the round keys backwards. cnt never exceeds nr-1,
    // so the subtraction is always non-negative.
    function automatic int round_idx(input int cnt, input logic dec, input int nr);
        return dec ? (nr - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/clb128_round_seq.sv
// Iterative CLB-128 round sequencer: holds the state and drives an external round datapath once per cycle.
// Latency: a block accepted at edge k shows out_valid after edge k+NR; at least NR+2 cycles per block.
// Backpressure: DONE holds out_valid/out_data until out_ready; in_ready is only high in IDLE.
module clb128_round_seq #(
    parameter int NR = clb128_pkg::NR,
    parameter int W  = clb128_pkg::W,
    parameter int CW = clb128_pkg::CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_dec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [W-1:0]  rf_state,
    output logic [CW-1:0] rf_round,
    output logic          rf_last,
    input  logic [W-1:0]  rf_result,
    input  logic          clr,
    output logic          busy
);
    import clb128_pkg::*;

    localparam logic [CW-1:0] CNT_LAST = CW'(NR - 1);

    fsm_e          fsm_q, fsm_d;
    logic [W-1:0]  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dec_q, dec_d;

    // Next-state decode; rf_result is only selected in RUN so X outside RUN cannot reach state.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_data;
                    dec_d   = in_dec;
                    cnt_d   = '0;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = rf_result;
                if (cnt_q == CNT_LAST) begin
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                    cnt_d = '0;
                end
            end
            default: begin
                fsm_d = IDLE;
                cnt_d = '0;
            end
        endcase
        // Abort wins over any handshake; state and direction are left as they were.
        if (clr) begin
            fsm_d   = IDLE;
            cnt_d   = '0;
            state_d = state_q;
            dec_d   = dec_q;
        end
    end

    // State, counter and direction registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
        end
    end

    assign rf_state  = state_q;
    assign rf_round  = CW'(round_idx(int'(cnt_q), dec_q, NR));
    assign rf_last   = (fsm_q == RUN) && (cnt_q == CNT_LAST);
    assign out_data  = state_q;
    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q != IDLE);

endmodule

// File: tb/tb_clb128_round_seq.sv
// Self-checking bench for clb128_round_seq with a simple additive round function.
// Latency: checks out_valid exactly NR edges after acceptance.
// Backpressure: exercises out_ready stalls, aborts and mid-run reset.
module tb_clb128_round_seq;

    localparam int NRT = 20;
    localparam logic [127:0] SUM = 128'(NRT * (NRT + 1) / 2);

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_dec;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [127:0] rf_state;
    logic [4:0]   rf_round;
    logic         rf_last;
    logic [127:0] rf_result;
    logic         clr;
    logic         busy;

    int tests = 0;
    int fails = 0;

    clb128_round_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dec    (in_dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rf_state  (rf_state),
        .rf_round  (rf_round),
        .rf_last   (rf_last),
        .rf_result (rf_result),
        .clr       (clr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench round function: state + round index + 1.
    assign rf_result = rf_state + 128'(rf_round) + 128'd1;

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a block in IDLE; it is taken at the next edge.
    task automatic start(input logic [127:0] d, input logic dc);
        in_valid = 1'b1;
        in_data  = d;
        in_dec   = dc;
        check("accept_in_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        in_data  = rand128();
        in_dec   = ~dc;
        check("run_busy", 128'(busy), 128'd1);
        check("run_first_state", rf_state, d);
    endtask

    // Expected key schedule order: forwards for encrypt, backwards for decrypt.
    task automatic run_rounds(input logic dc, input int n);
        int exp_r;
        for (int i = 0; i < n; i++) begin
            exp_r = dc ? (NRT - 1 - i) : i;
            check("rf_round", 128'(rf_round), 128'(exp_r));
            check("rf_last", 128'(rf_last), 128'(i == NRT - 1));
            check("in_ready_run", 128'(in_ready), 128'd0);
            check("out_valid_run", 128'(out_valid), 128'd0);
            tick();
        end
    endtask

    task automatic finish_blk(input logic [127:0] exp, input int hold);
        check("done_valid", 128'(out_valid), 128'd1);
        check("done_data", out_data, exp);
        check("done_rf_last", 128'(rf_last), 128'd0);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("stall_valid", 128'(out_valid), 128'd1);
            check("stall_data", out_data, exp);
            check("stall_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_valid", 128'(out_valid), 128'd0);
        check("drain_in_ready", 128'(in_ready), 128'd1);
        check("drain_busy", 128'(busy), 128'd0);
        check("drain_state_kept", out_data, exp);
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] nd;
        logic         dc;
        logic         seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dec    = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;

        // Reset
        repeat (3) tick();
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_rf_state", rf_state, 128'd0);
        check("rst_rf_round", 128'(rf_round), 128'd0);
        check("rst_rf_last", 128'(rf_last), 128'd0);
        rst_n = 1'b1;
        tick();
        check("idle_hold", 128'(in_ready), 128'd1);

        // Directed encrypt and decrypt
        start(128'd0, 1'b0);
        run_rounds(1'b0, NRT);
        finish_blk(128'hD2, 0);

        start(128'h100, 1'b1);
        run_rounds(1'b1, NRT);
        finish_blk(128'h1D2, 2);

        // Backpressure: ten stalled cycles, then a new block offered with out_ready
        d = rand128();
        start(d, 1'b0);
        run_rounds(1'b0, NRT);
        check("bp_done_data", out_data, d + SUM);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 128'(out_valid), 128'd1);
            check("bp_data", out_data, d + SUM);
            check("bp_in_ready", 128'(in_ready), 128'd0);
        end
        nd        = rand128();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = nd;
        in_dec    = 1'b1;
        check("bp_no_overlap", 128'(in_ready), 128'd0);
        tick();
        out_ready = 1'b0;
        check("bp_idle_ready", 128'(in_ready), 128'd1);
        check("bp_idle_valid", 128'(out_valid), 128'd0);
        check("bp_not_taken", out_data, d + SUM);
        tick();
        in_valid = 1'b0;
        check("bp_accept_busy", 128'(busy), 128'd1);
        check("bp_accept_state", rf_state, nd);
        run_rounds(1'b1, NRT);
        finish_blk(nd + SUM, 1);

        // Abort at round 7
        start(rand128(), 1'b0);
        run_rounds(1'b0, 7);
        check("abort_round7", 128'(rf_round), 128'd7);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("abort_in_ready", 128'(in_ready), 128'd1);
        check("abort_busy", 128'(busy), 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("abort_no_valid", 128'(seen), 128'd0);

        // clr beats in_valid in IDLE
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 128'd9;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_idle_ready", 128'(in_ready), 128'd1);
        check("clr_idle_busy", 128'(busy), 128'd0);

        start(128'd5, 1'b0);
        run_rounds(1'b0, NRT);
        finish_blk(128'hD7, 0);

        // Reset in the middle of a run
        start(rand128(), 1'b0);
        run_rounds(1'b0, 12);
        check("mid_round12", 128'(rf_round), 128'd12);
        in_valid = 1'b1;
        in_data  = rand128();
        rst_n    = 1'b0;
        tick();
        check("mid_rst_state", rf_state, 128'd0);
        check("mid_rst_out", out_data, 128'd0);
        check("mid_rst_ready", 128'(in_ready), 128'd1);
        check("mid_rst_busy", 128'(busy), 128'd0);
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        check("mid_post_busy", 128'(busy), 128'd0);
        check("mid_post_state", rf_state, 128'd0);

        // Randomized blocks against the closed-form model
        for (int b = 0; b < 8; b++) begin
            d  = rand128();
            dc = 1'($urandom_range(0, 1));
            start(d, dc);
            run_rounds(dc, NRT);
            finish_blk(d + SUM, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clb128_round_seq.md
Name: clb128_round_seq

Overview:
Iterative round sequencer for the CLB-128 cipher core. It owns the 128-bit state register and round counter, and drives one shared combinational round datapath once per cycle for NR cycles. That datapath is external to this block: key add, S-box layer, then the nibble position permutation. Valid/ready handshakes sit on both the input and output sides, and one block is in flight at a time.

Parameters:
NR, 20, number of rounds; legal range 2..31.
W, 128, state width; fixed at 128, a parameter for readability only.
CW, 5, round counter width; must satisfy 2**CW > NR.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input block offered
in_ready  out  1  sequencer can accept a block
in_data  in  128  plaintext/ciphertext block
in_dec  in  1  direction, sampled with in_data; 1 = decrypt
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  128  result block
rf_state  out  128  state presented to the round datapath
rf_round  out  CW  round index for round-key selection
rf_last  out  1  current round is the final round
rf_result  in  128  round datapath output, combinational from rf_state/rf_round
clr  in  1  synchronous abort, returns to IDLE
busy  out  1  high in RUN or DONE

Behaviour:
- Registers: state[127:0], cnt[CW-1:0], dec, fsm in {IDLE, RUN, DONE}.
- Reset (rst_n=0 at a clk edge): fsm=IDLE, state=0, cnt=0, dec=0.
- Resulting reset outputs: in_ready=1, out_valid=0, busy=0, out_data=0, rf_state=0, rf_round=0, rf_last=0.
- Output decode:
  - rf_state = state.
  - rf_round = dec ? NR-1-cnt : cnt.
  - rf_last = (fsm==RUN) && (cnt==NR-1).
  - out_data = state.
  - in_ready = (fsm==IDLE).
  - out_valid = (fsm==DONE).
- IDLE: on in_valid, state<=in_data, dec<=in_dec, cnt<=0, go RUN. With no in_valid, all registers hold.
- RUN, every cycle: state<=rf_result.
  - If cnt==NR-1: go DONE, cnt holds.
  - Otherwise cnt<=cnt+1.
  - Exactly NR round evaluations occur per block.
- DONE: out_valid held high and out_data stable until out_ready. On out_ready, go IDLE and cnt<=0. state is not cleared.
- Latency: accept at edge k, out_valid high after edge k+NR. Throughput is one block per NR+2 cycles minimum.
- No overlap: in_ready stays 0 in DONE even while out_ready=1. The next block is accepted the cycle after IDLE is re-entered.
- in_valid/in_data/in_dec are ignored outside IDLE; the producer must hold them until in_ready.
- clr has priority over everything except rst_n. Next state is IDLE and cnt<=0; state and dec hold.
  - An in-flight block is discarded and no out_valid is produced.
  - clr together with in_valid in IDLE: the block is not accepted.
- No arithmetic wrap: cnt never exceeds NR-1. NR-1-cnt is computed in CW bits and is always non-negative.
- rf_result is sampled only in RUN; X on rf_result outside RUN must not propagate to state.

Decomposition:
- Package clb128_pkg:
  - NR, W and CW constants.
  - fsm enum {IDLE=2'd0, RUN=2'd1, DONE=2'd2}.
  - Round-index helper function (enc/dec mapping).
- No sub-module needed.
- The round datapath (key add, S-box layer, position permutation) stays a separate combinational block wired by the parent core.

Test Plan:
- Bench round function is rf_result = rf_state + rf_round + 1, with NR=20.
- Reset: hold rst_n=0 for 3 cycles -> in_ready=1, out_valid=0, busy=0, out_data=0.
- Encrypt: in_data=0, in_dec=0, accepted at edge k -> rf_round sequence 0,1,...,19 and rf_last only at 19. out_valid after edge k+20 with out_data=128'hD2 (sum 1..20 = 210).
- Decrypt: in_data=128'h100, in_dec=1 -> rf_round sequence 19,...,0 and out_data=128'h1D2.
- Backpressure: keep out_ready=0 for 10 cycles after DONE -> out_valid and out_data stay stable and in_ready=0. Then out_ready=1 -> IDLE next cycle. A new block offered the same cycle is accepted one cycle later.
- Abort: assert clr when cnt==7 -> IDLE next cycle, no out_valid ever. Then send in_data=5, in_dec=0 -> out_data=128'hD7.
- Reset mid-run: pull rst_n=0 at cnt==12 -> next cycle state=0, fsm=IDLE. in_data sent during RUN and during reset is never accepted.
